// File: rtl/screen_streamer.sv
// screen_streamer
//   Once per frame, fetches the 256-byte screen region from the CPU over its
//   stall-prone read port. The bytes are buffered in a small first-word
//   fall-through FIFO and presented downstream as a valid/ready byte stream
//   with first/last markers.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   frame_start       one-cycle pulse that starts a frame fetch
//   scr_read          read request to the CPU (level, held until ack)
//   scr_read_idx      byte index requested
//   scr_read_byte     CPU data, valid with scr_read_ack
//   scr_read_ack      one-cycle CPU acknowledge
//   out_valid/ready   stream handshake towards the display driver
//   out_byte          stream data
//   out_first         out_byte is index 0 of the frame
//   out_last          out_byte is the final index of the frame
//   busy              a fetch or drain is in progress
//   overrun           sticky: frame_start arrived while not idle
//
// Fetch FSM
//   state  | meaning
//   IDLE   | waiting for frame_start
//   REQ    | request byte idx (only while the FIFO has a free slot)
//   GAP    | one dead cycle between reads so the CPU can resume fetching
//   DRAIN  | all bytes fetched, waiting for the FIFO to empty

module screen_streamer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_BYTES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  output logic       scr_read,
  output logic [7:0] scr_read_idx,
  input  logic [7:0] scr_read_byte,
  input  logic       scr_read_ack,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_first,
  output logic       out_last,
  output logic       busy,
  output logic       overrun
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       LAST_IDX = 8'(FRAME_BYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state;
  logic [7:0]       idx;

  // FIFO entry: {data[7:0], first, last}
  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [9:0]       head;
  logic             fifo_empty;
  logic             has_room;
  logic             push;
  logic             pop;

  assign fifo_empty = (count == '0);
  // The request itself is the in-flight byte, so one free slot is enough.
  assign has_room   = (count < DEPTH_C);

  assign scr_read     = (state == S_REQ) && has_room;
  assign scr_read_idx = idx;
  // An ack is only meaningful while a request is actually on the port.
  assign push         = scr_read && scr_read_ack;

  assign head      = mem[rd_ptr];
  assign out_valid = !fifo_empty;
  assign out_byte  = head[9:2];
  // Gated by out_valid so stale or uninitialised entries never show a marker.
  assign out_first = out_valid && head[1];
  assign out_last  = out_valid && head[0];
  assign pop       = out_valid && out_ready;

  // busy drops in the same cycle DRAIN sees an empty FIFO, one cycle before
  // the FSM is back in IDLE. A frame_start in that cycle is an overrun.
  assign busy = (state != S_IDLE) && !((state == S_DRAIN) && fifo_empty);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      if (frame_start && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            idx   <= '0;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (push) begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (idx == LAST_IDX) begin
            state <= S_DRAIN;
          end else begin
            idx   <= idx + 8'd1;
            state <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      // Push and pop together leave the count unchanged, including when full:
      // the slot written is the one being read out in the same cycle.
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {scr_read_byte, (idx == 8'd0), (idx == LAST_IDX)};
    end
  end

endmodule

// File: tb/tb_screen_streamer.sv
module tb_screen_streamer;

  localparam int DEPTH  = 4;
  localparam int NBYTES = 256;
  localparam int BUDGET = 8000;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_start;
  logic       scr_read;
  logic [7:0] scr_read_idx;
  logic [7:0] scr_read_byte;
  logic       scr_read_ack;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       out_first;
  logic       out_last;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // shared stimulus knobs, written by the main sequence only
  int stall_max    = 0;
  int gap_check_en = 0;
  int inj_req      = 0;

  // reference-model state, written by the monitor only
  int rx_cnt, pushes, pops, exp_req_idx, low_run, n_first, n_last;

  always #5 clk = ~clk;

  screen_streamer #(.FIFO_DEPTH(DEPTH), .FRAME_BYTES(NBYTES)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .scr_read(scr_read), .scr_read_idx(scr_read_idx),
    .scr_read_byte(scr_read_byte), .scr_read_ack(scr_read_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_first(out_first), .out_last(out_last),
    .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // CPU model: answers each request after 1 + rand(0..stall_max) cycles with
  // idx ^ 8'hA5; can also inject a stray ack on demand.
  initial begin
    int wait_cnt;
    int inj_seen;
    scr_read_ack  = 1'b0;
    scr_read_byte = 8'h00;
    wait_cnt      = 1;
    inj_seen      = 0;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        scr_read_ack = 1'b0;
        wait_cnt     = 1;
      end else if (scr_read_ack) begin
        scr_read_ack = 1'b0;
      end else if (inj_req != inj_seen) begin
        inj_seen      = inj_req;
        scr_read_ack  = 1'b1;
        scr_read_byte = 8'h3C;
      end else if (scr_read) begin
        if (wait_cnt == 0) begin
          scr_read_ack  = 1'b1;
          scr_read_byte = scr_read_idx ^ 8'hA5;
          wait_cnt      = 1 + int'($urandom_range(32'(stall_max), 32'd0));
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Monitor and reference model: a frame is the sequence idx = 0..255 with
  // data idx^A5, first on idx 0, last on idx 255; FIFO occupancy is the
  // number of accepted acks minus accepted stream bytes.
  initial begin
    logic       prev_read, hold_pending;
    logic [7:0] prev_idx, hold_byte, exp_byte;
    logic       hold_first, hold_last;
    int         occ;
    prev_read = 1'b0; hold_pending = 1'b0; prev_idx = '0;
    hold_byte = '0; hold_first = 1'b0; hold_last = 1'b0;
    rx_cnt = 0; pushes = 0; pops = 0; exp_req_idx = 0; low_run = -1;
    n_first = 0; n_last = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rx_cnt = 0; pushes = 0; pops = 0; exp_req_idx = 0; low_run = -1;
        n_first = 0; n_last = 0; prev_read = 1'b0; hold_pending = 1'b0;
        continue;
      end
      if (frame_start && !busy) begin
        rx_cnt = 0; exp_req_idx = 0; low_run = -1; n_first = 0; n_last = 0;
      end
      if (hold_pending) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_byte",  int'(out_byte), int'(hold_byte));
        chk("hold_first", int'(out_first), int'(hold_first));
        chk("hold_last",  int'(out_last), int'(hold_last));
      end
      occ = pushes - pops;
      chk("fifo_occ_le_depth", int'(occ <= DEPTH), 1);
      if (occ == DEPTH) chk("no_read_while_full", int'(scr_read), 0);
      if (scr_read && prev_read) chk("idx_stable", int'(scr_read_idx), int'(prev_idx));
      if (scr_read && !prev_read) begin
        if (gap_check_en != 0 && low_run >= 0) chk("req_gap_len", low_run, 1);
        low_run = 0;
      end else if (!scr_read && low_run >= 0) begin
        low_run++;
      end
      if (scr_read && scr_read_ack) begin
        chk("req_order", int'(scr_read_idx), exp_req_idx);
        exp_req_idx++;
        pushes++;
      end
      if (out_valid && out_ready) begin
        exp_byte = 8'(rx_cnt) ^ 8'hA5;
        chk("no_extra_byte", int'(rx_cnt < NBYTES), 1);
        chk("out_byte",  int'(out_byte), int'(exp_byte));
        chk("out_first", int'(out_first), int'(rx_cnt == 0));
        chk("out_last",  int'(out_last), int'(rx_cnt == NBYTES - 1));
        if (out_first) n_first++;
        if (out_last)  n_last++;
        rx_cnt++;
        pops++;
      end
      hold_pending = out_valid && !out_ready;
      hold_byte    = out_byte;
      hold_first   = out_first;
      hold_last    = out_last;
      prev_read    = scr_read;
      prev_idx     = scr_read_idx;
    end
  end

  typedef struct {
    int stall_max;   // CPU ack stall 0..stall_max extra cycles
    int gap_at;      // drop out_ready when this many bytes received (-1 none)
    int gap_len;     // cycles out_ready held low
    int sec_at;      // second frame_start after this many acks (-1 none)
    int ready_rand;  // random out_ready
    int spurious;    // stray ack in IDLE before the frame
    int drop_start;  // frame_start in the cycle busy falls
    int gap_chk;     // expect exactly one low cycle between requests
    int exp_bytes;   // bytes delivered when busy falls
    int exp_overrun;
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; frame_start = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int with_reset);
    int finished, gap_done, gap_left, sec_done, quiet;
    int rx_at_fall, f_at_fall, l_at_fall;
    finished = 0; gap_done = 0; gap_left = 0; sec_done = 0;
    rx_at_fall = 0; f_at_fall = 0; l_at_fall = 0;
    if (with_reset != 0) do_reset();
    stall_max    = v.stall_max;
    gap_check_en = v.gap_chk;
    out_ready    = 1'b1;
    if (v.spurious != 0) begin
      inj_req++;
      repeat (3) begin @(posedge clk); #1; end
      chk("spurious_no_write", int'(out_valid), 0);
      chk("spurious_no_busy",  int'(busy), 0);
    end
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      frame_start = 1'b0;
      if (v.ready_rand != 0) begin
        out_ready = ($urandom_range(3, 0) != 0);
      end else if (v.gap_at >= 0 && gap_done == 0 && rx_cnt >= v.gap_at) begin
        out_ready = 1'b0; gap_left = v.gap_len; gap_done = 1;
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) out_ready = 1'b1;
      end
      if (v.sec_at >= 0 && sec_done == 0 && pushes >= v.sec_at) begin
        frame_start = 1'b1; sec_done = 1;
      end
      if (!busy) begin
        finished   = 1;
        rx_at_fall = rx_cnt; f_at_fall = n_first; l_at_fall = n_last;
        if (v.drop_start != 0) frame_start = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (finished == 0) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: busy still high after %0d cycles, required to fall", BUDGET);
    end else begin
      chk("bytes_at_busy_fall", rx_at_fall, v.exp_bytes);
      chk("first_once", f_at_fall, 1);
      chk("last_once",  l_at_fall, 1);
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
    out_ready   = 1'b1;
    quiet = 1;
    repeat (10) begin
      if (busy || scr_read) quiet = 0;
      @(posedge clk); #1;
    end
    chk("idle_after_frame", quiet, 1);
    chk("overrun", int'(overrun), v.exp_overrun);
  endtask

  initial begin
    int found;
    reset = 1'b1; frame_start = 1'b0; out_ready = 1'b1;
    //             stall gap_at gap_len sec rnd spur drop gchk bytes ovr
    vecs[0] = '{0,  -1,  0,  -1, 0, 0, 0, 1, 256, 0};
    vecs[1] = '{20, -1,  0,  -1, 0, 0, 0, 1, 256, 0};
    vecs[2] = '{0,  60, 50,  -1, 0, 0, 0, 0, 256, 0};
    vecs[3] = '{3,  -1,  0, 100, 0, 0, 0, 1, 256, 1};
    vecs[4] = '{5,  -1,  0,  -1, 1, 0, 0, 0, 256, 0};
    vecs[5] = '{0,  -1,  0,  -1, 0, 1, 1, 1, 256, 1};

    do_reset();
    chk("rst_scr_read",  int'(scr_read), 0);
    chk("rst_idx",       int'(scr_read_idx), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_first", int'(out_first), 0);
    chk("rst_out_last",  int'(out_last), 0);
    chk("rst_busy",      int'(busy), 0);
    chk("rst_overrun",   int'(overrun), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1);

    // reset in the middle of a frame while byte 37 is being requested
    do_reset();
    stall_max = 0; gap_check_en = 1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    found = 0;
    for (int c = 0; c < 1000; c++) begin
      if (pushes == 37 && scr_read) begin found = 1; break; end
      @(posedge clk); #1;
    end
    chk("reach_byte37", found, 1);
    chk("idx_at_37", int'(scr_read_idx), 37);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_scr_read",  int'(scr_read), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy",      int'(busy), 0);
    inj_req++;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("late_ack_out_valid", int'(out_valid), 0);
    chk("late_ack_busy",      int'(busy), 0);
    chk("late_ack_scr_read",  int'(scr_read), 0);
    run_vec(vecs[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_streamer.md
Name: screen_streamer

Overview:
- Downstream consumer of the CPU's screen-read port. Pulls the 256-byte framebuffer (32 lines x 8 bytes, MSB = leftmost pixel) from the CPU once per frame.
- Buffers the bytes in a small FIFO and presents them as a valid/ready byte stream, with first/last markers, to the display driver (OLED/LED-matrix serializer).
- Decouples the CPU's stall-prone read handshake from the display's timing.

Parameters:
- FIFO_DEPTH, 4: entries in the internal byte FIFO; power of two, at least 2.
- FRAME_BYTES, 256: bytes fetched per frame; index width is 8 bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame_start  input  1  single-cycle pulse that starts one frame fetch (e.g. the 60 Hz tick)
- scr_read  output  1  read request to the CPU; level, held until acked
- scr_read_idx  output  8  byte index 0..255 within the screen region
- scr_read_byte  input  8  data from the CPU; valid when scr_read_ack=1
- scr_read_ack  input  1  one-cycle acknowledge from the CPU
- out_valid  output  1  stream byte available
- out_ready  input  1  downstream accepts the byte when out_valid && out_ready
- out_byte  output  8  stream data
- out_first  output  1  qualifies out_byte as index 0 of a frame
- out_last  output  1  qualifies out_byte as index 255 of a frame
- busy  output  1  a frame fetch or drain is in progress
- overrun  output  1  sticky: frame_start arrived while busy

Behaviour:
- Interface: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values: scr_read=0, scr_read_idx=0, out_valid=0, out_first=0, out_last=0, busy=0, overrun=0. The FIFO is emptied and the fetch FSM goes to IDLE.
- Reset mid-operation aborts the frame. No further requests are issued and the FIFO contents are discarded.
- Fetch FSM states:
  - IDLE: on frame_start, load idx=0 and go to REQ. busy=1 from the next cycle.
  - REQ: scr_read=1 and scr_read_idx=idx, both stable until scr_read_ack.
    - On ack: write {scr_read_byte, idx==0, idx==255} into the FIFO, deassert scr_read the next cycle and go to GAP.
    - A request is only raised when the FIFO has at least one free slot, counting the in-flight byte. Otherwise the FSM sits in REQ with scr_read=0.
  - GAP: scr_read=0 for exactly one cycle. This lets the CPU resume instruction fetch between bytes.
    - If idx==255, go to DRAIN.
    - Otherwise idx<=idx+1 and return to REQ.
  - DRAIN: wait until the FIFO is empty and no output byte is pending, then go to IDLE; busy drops the same cycle.
- scr_read_ack arriving while scr_read=0 is ignored; no write, no state change.
- idx is 8-bit and does not wrap within a frame; the frame ends after index 255.
- FIFO:
  - Synchronous, with first-word fall-through to the out_* signals.
  - Push and pop in the same cycle are allowed when full: the pop frees the slot. This is never needed by construction, but it must work.
  - out_byte, out_first and out_last hold stable while out_valid && !out_ready.
- Latency: a byte acked at cycle N appears with out_valid=1 at cycle N+1 when the FIFO was empty.
- Throughput: at most one byte per 3 cycles (REQ-ack, GAP, REQ), plus any CPU stall.
- frame_start while busy:
  - Ignored; overrun<=1, sticky until reset.
  - frame_start in the same cycle as busy falling is also counted as overrun.
  - frame_start in IDLE with busy=0 always starts a frame.
- out_first and out_last occur exactly once per frame, on bytes 0 and 255 respectively.

Test Plan:
- Immediate-ack CPU model (ack one cycle after request), out_ready=1, frame_start pulse -> 256 bytes emitted in index order with data = idx^8'hA5. out_first only on byte 0, out_last only on byte 255. scr_read low for exactly 1 cycle between requests. busy falls after the last byte is accepted.
- CPU model stalling each ack by a random 0-20 cycles -> scr_read_idx stable while scr_read=1. No duplicate or missing indices. Stream identical to the immediate-ack case.
- out_ready=0 for 50 cycles mid-frame -> at most FIFO_DEPTH bytes buffered. scr_read stays 0 while the FIFO is full. Held out_byte unchanged. No loss after out_ready returns.
- Second frame_start at byte 100 -> overrun=1, the frame completes normally with 256 bytes, and overrun stays 1 after busy falls.
- reset asserted at byte 37 with scr_read=1 -> next cycle scr_read=0, out_valid=0, busy=0. A late ack is ignored. A following frame_start produces a clean frame starting at idx 0.
- Spurious scr_read_ack in IDLE, then a frame_start in the cycle busy drops -> no FIFO write from the spurious ack; overrun=1 and no new frame starts.
